// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_pkg
//  Purpose  : Shared types and constants for the sequential signed divider.
//             Holds the divider state encoding and the default sizing.
//  Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int c_default_width     = 32;
    localparam int c_default_cnt_w     = 6;
    localparam int c_default_last_iter = c_default_width - 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_step
//  Purpose  : One combinational restoring-division iteration. Shifts the
//             {rem,quo} pair left by one, subtracts the divisor when it fits
//             and shifts the resulting quotient bit into quo[0].
//  Ports    : rem      [WIDTH:0]   partial remainder in
//             quo      [WIDTH-1:0] quotient/dividend shift register in
//             divisor  [WIDTH-1:0] magnitude of the divisor
//             next_rem [WIDTH:0]   partial remainder out
//             next_quo [WIDTH-1:0] quotient shift register out
//  Revision : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   next_rem,
    output logic [WIDTH-1:0] next_quo
);

    // Carry one extra bit so the shifted remainder can never wrap before the
    // compare, even though the remainder always stays below the divisor.
    logic [WIDTH+1:0] w_shift;
    logic             w_fits;

    assign w_shift  = {rem, quo[WIDTH-1]};
    assign w_fits   = (w_shift >= {2'b00, divisor});
    assign next_rem = w_fits ? (WIDTH+1)'(w_shift - {2'b00, divisor}) : w_shift[WIDTH:0];
    assign next_quo = {quo[WIDTH-2:0], w_fits};

endmodule : div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Multicycle signed integer divider (MIPS DIV). Quotient goes to
//             lo, remainder (sign of dividend) to hi; divide-by-zero is
//             flagged alongside ready.
//  Ports    : clk       rising-edge clock
//             reset     synchronous active-low reset
//             start     one-cycle request, honoured only while idle
//             a, b      dividend / divisor (two's complement)
//             hi, lo    remainder / quotient, held until next completion
//             ready     one-cycle result-valid pulse
//             div_zero  one-cycle pulse with ready when b was zero
//             busy      high while a division is in progress
//             unsigned_op (only with DIV_UNSIGNED_EN) selects DIVU
//  Options  : DIV_UNSIGNED_EN adds the unsigned_op port.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int CNT_W = c_default_cnt_w
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef DIV_UNSIGNED_EN
    input  logic             unsigned_op,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             ready,
    output logic             div_zero,
    output logic             busy
);

    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    div_state_t       w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH:0]   r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_signed;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_zero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_ready;
    logic             r_div_zero;

    logic             w_signed_op;
    logic             w_b_zero;
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

`ifdef DIV_UNSIGNED_EN
    assign w_signed_op = ~unsigned_op;
`else
    assign w_signed_op = 1'b1;
`endif

    assign w_b_zero = (b == '0);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (r_rem),
        .quo      (r_quo),
        .divisor  (r_div),
        .next_rem (w_rem_nxt),
        .next_quo (w_quo_nxt)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = w_b_zero ? DONE : PREP;
                end
            end
            PREP: w_state_nxt = RUN;
            RUN: begin
                if (r_cnt == c_last_iter) begin
                    w_state_nxt = FIX;
                end
            end
            FIX:     w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_quo      <= '0;
            r_div      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_signed   <= 1'b0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_zero     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_ready    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_ready    <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_signed <= w_signed_op;
                        r_sign_q <= w_signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_sign_r <= w_signed_op & a[WIDTH-1];
                        r_zero   <= w_b_zero;
                    end
                end
                PREP: begin
                    // The most negative value negates to itself, which read
                    // as unsigned is exactly its magnitude.
                    r_quo <= (r_signed && r_a[WIDTH-1]) ? -r_a : r_a;
                    r_div <= (r_signed && r_b[WIDTH-1]) ? -r_b : r_b;
                    r_rem <= '0;
                    r_cnt <= '0;
                end
                RUN: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FIX: begin
                    r_lo <= r_sign_q ? -r_quo : r_quo;
                    r_hi <= r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
                end
                DONE: begin
                    r_ready    <= 1'b1;
                    r_div_zero <= r_zero;
                end
                default: ;
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign ready    = r_ready;
    assign div_zero = r_div_zero;
    assign busy     = (r_state == PREP) || (r_state == RUN) || (r_state == FIX);

endmodule : seq_divider
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider
//  Purpose  : Self-checking bench for seq_divider. A cycle-count reference
//             model computes results with 64-bit integer arithmetic; a
//             compare process checks every output each cycle, and directed
//             cases pin hand-computed values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int  W   = 32;
    localparam int  LAT = W + 3;
`ifdef DIV_UNSIGNED_EN
    localparam logic c_uns_en = 1'b1;
`else
    localparam logic c_uns_en = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          uop   = 1'b0;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  b     = '0;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          ready;
    logic          div_zero;
    logic          busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_divider #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
`ifdef DIV_UNSIGNED_EN
        .unsigned_op (uop),
`endif
        .a           (a),
        .b           (b),
        .hi          (hi),
        .lo          (lo),
        .ready       (ready),
        .div_zero    (div_zero),
        .busy        (busy)
    );

    // ------------------------------------------------------------------
    // Reference arithmetic: 64-bit math avoids the MIN/-1 overflow trap.
    // Returns {remainder, quotient} truncated to W bits.
    // ------------------------------------------------------------------
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                            input logic uns);
        longint sx, sy, q, r;
        sx = uns ? longint'({32'd0, x}) : longint'($signed(x));
        sy = uns ? longint'({32'd0, y}) : longint'($signed(y));
        q  = sx / sy;
        r  = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: counts edges remaining until ready.
    // ------------------------------------------------------------------
    int           m_left  = 0;
    logic         m_zero  = 1'b0;
    logic [W-1:0] m_q     = '0;
    logic [W-1:0] m_r     = '0;
    logic [W-1:0] e_hi    = '0;
    logic [W-1:0] e_lo    = '0;
    logic         e_ready = 1'b0;
    logic         e_dz    = 1'b0;
    logic         chk_en  = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            m_left  <= 0;
            m_zero  <= 1'b0;
            e_hi    <= '0;
            e_lo    <= '0;
            e_ready <= 1'b0;
            e_dz    <= 1'b0;
        end else begin
            e_ready <= 1'b0;
            e_dz    <= 1'b0;
            if (m_left == 0) begin
                if (start) begin
                    if (b == '0) begin
                        m_left <= 1;
                        m_zero <= 1'b1;
                    end else begin
                        {m_r, m_q} <= ref_div(a, b, uop & c_uns_en);
                        m_left     <= LAT;
                        m_zero     <= 1'b0;
                    end
                end
            end else begin
                m_left <= m_left - 1;
                // Results land one edge before the ready pulse.
                if (m_left == 2 && !m_zero) begin
                    e_lo <= m_q;
                    e_hi <= m_r;
                end
                if (m_left == 1) begin
                    e_ready <= 1'b1;
                    e_dz    <= m_zero;
                end
            end
        end
    end

    // Compare process: every output, every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready",    {31'd0, ready},    {31'd0, e_ready});
            check("div_zero", {31'd0, div_zero}, {31'd0, e_dz});
            check("busy",     {31'd0, busy},     {31'd0, (m_left >= 2) && !m_zero});
            check("hi",       hi, e_hi);
            check("lo",       lo, e_lo);
        end
    end

    // ------------------------------------------------------------------
    // Driver: issue one request and wait (bounded) for ready.
    // ------------------------------------------------------------------
    task automatic run_div(input logic [31:0] x, input logic [31:0] y, input logic u,
                           input int extra_at, output int lat, output logic got_dz);
        a      = x;
        b      = y;
        uop    = u;
        start  = 1'b1;
        lat    = -1;
        got_dz = 1'b0;
        for (int i = 1; i <= LAT + 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                a     = $urandom;
                b     = $urandom;
                uop   = ~u;
            end
            if (extra_at != 0) begin
                if (i == extra_at) begin
                    start = 1'b1;
                    a     = $urandom;
                    b     = $urandom | 32'd1;
                end else if (i == extra_at + 1) begin
                    start = 1'b0;
                end
            end
            if (ready) begin
                lat    = i - 1;
                got_dz = div_zero;
                break;
            end
        end
        start = 1'b0;
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got no ready want ready within %0d cycles", LAT + 10);
        end
    endtask

    task automatic pin(input string nm, input logic [31:0] x, input logic [31:0] y,
                       input logic u, input int extra_at,
                       input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                       input logic exp_dz, input int exp_lat);
        int   lat;
        logic dz;
        run_div(x, y, u, extra_at, lat, dz);
        check({nm, "_lat"}, lat, exp_lat);
        check({nm, "_lo"},  lo,  exp_lo);
        check({nm, "_hi"},  hi,  exp_hi);
        check({nm, "_dz"},  {31'd0, dz}, {31'd0, exp_dz});
    endtask

    initial begin
        int           lat;
        logic         dz;
        logic [31:0]  ra, rb;
        logic         ru;

        reset = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_hi",    hi, 32'd0);
        check("rst_lo",    lo, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        pin("d100_7",   32'd100,        32'd7,          1'b0, 0, 32'd14,         32'd2,          1'b0, LAT);
        pin("dm7_2",    32'hFFFF_FFF9,  32'd2,          1'b0, 0, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, LAT);
        pin("d7_m2",    32'd7,          32'hFFFF_FFFE,  1'b0, 0, 32'hFFFF_FFFD,  32'd1,          1'b0, LAT);
        pin("dmin_m1",  32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 0, 32'h8000_0000,  32'd0,          1'b0, LAT);
        pin("d100_7b",  32'd100,        32'd7,          1'b0, 0, 32'd14,         32'd2,          1'b0, LAT);
        pin("d5_0",     32'd5,          32'd0,          1'b0, 0, 32'd14,         32'd2,          1'b1, 1);
        pin("dignore",  32'd100,        32'd7,          1'b0, 7, 32'd14,         32'd2,          1'b0, LAT);

        // Abort a division part-way through RUN.
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_hi",    hi, 32'd0);
        check("abort_lo",    lo, 32'd0);
        check("abort_ready", {31'd0, ready}, 32'd0);
        check("abort_busy",  {31'd0, busy},  32'd0);
        reset = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        pin("after_rst", 32'd100, 32'd7, 1'b0, 0, 32'd14, 32'd2, 1'b0, LAT);

`ifdef DIV_UNSIGNED_EN
        pin("divu", 32'hFFFF_FFFF, 32'd2, 1'b1, 0, 32'h7FFF_FFFF, 32'd1, 1'b0, LAT);
`endif

        // Randomised traffic, checked cycle by cycle by the compare process.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       ra = 32'h8000_0000;
                1:       ra = $urandom_range(0, 50);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 20);
                3:       rb = -$urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            ru = c_uns_en & $urandom_range(0, 1);
            run_div(ra, rb, ru, 0, lat, dz);
            check("rnd_lat", lat, (rb == 32'd0) ? 1 : LAT);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_divider
`default_nettype wire
